idli_sqi_resp_m: RTL and testbench

IDLI_SQI_RESP_M -- requirements
Module: idli_sqi_resp_m

---
 rtl/idli_sqi_resp_m.sv | 170 +++++++++++++++++
 tb/tb_idli_sqi_resp_m.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/idli_sqi_resp_m.sv
// SQI responder: decodes READ (0x03) / WRITE (0x02) with a 16-bit address and
// streams bytes to or from a simple byte memory with one-cycle read latency.
package idli_sqi_pkg;
   typedef enum logic {
      SQI_IO_MODE_IN  = 1'b0,
      SQI_IO_MODE_OUT = 1'b1
   } sqi_io_mode_t;
endpackage

module idli_sqi_resp_m
   import idli_sqi_pkg::*;
(
   input  logic         i_resp_gck,
   input  logic         i_resp_rst_n,
   input  logic         i_resp_sck,
   input  logic         i_resp_cs,
   input  logic [3:0]   i_resp_sio,
   output logic [3:0]   o_resp_sio,
   output sqi_io_mode_t o_resp_io_mode,
   output logic [15:0]  o_resp_mem_addr,
   output logic         o_resp_mem_rd,
   input  logic [7:0]   i_resp_mem_rdata,
   output logic         o_resp_mem_wr,
   output logic [7:0]   o_resp_mem_wdata
);
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_INSTR,
      ST_ADDR,
      ST_DUMMY,
      ST_RDATA,
      ST_WDATA,
      ST_IGNORE
   } state_t;

   state_t     state_reg;
   logic [2:0] cnt_reg;
   logic       sck_prev_reg;
   logic       is_read_reg;
   logic [3:0] nib_reg;
   logic [7:0] rbyte_reg;
   logic       rd_pend_reg;
   logic       sck_rise;
   logic       sck_fall;

   assign sck_rise = i_resp_sck & ~sck_prev_reg;
   assign sck_fall = ~i_resp_sck & sck_prev_reg;

   always_ff @(posedge i_resp_gck or negedge i_resp_rst_n) begin
      if (!i_resp_rst_n) begin
         state_reg        <= ST_IDLE;
         cnt_reg          <= 3'd0;
         sck_prev_reg     <= 1'b0;
         is_read_reg      <= 1'b0;
         nib_reg          <= 4'd0;
         rbyte_reg        <= 8'd0;
         rd_pend_reg      <= 1'b0;
         o_resp_sio       <= 4'd0;
         o_resp_io_mode   <= SQI_IO_MODE_IN;
         o_resp_mem_addr  <= 16'd0;
         o_resp_mem_rd    <= 1'b0;
         o_resp_mem_wr    <= 1'b0;
         o_resp_mem_wdata <= 8'd0;
      end else begin
         sck_prev_reg  <= i_resp_sck;
         o_resp_mem_rd <= 1'b0;
         o_resp_mem_wr <= 1'b0;
         // read data arrives one cycle after the strobe
         rd_pend_reg   <= o_resp_mem_rd;
         if (rd_pend_reg)
            rbyte_reg <= i_resp_mem_rdata;
         // a write holds its address for the strobe cycle, then advances
         if (o_resp_mem_wr)
            o_resp_mem_addr <= o_resp_mem_addr + 16'd1;

         if (i_resp_cs) begin
            state_reg      <= ST_IDLE;
            cnt_reg        <= 3'd0;
            o_resp_sio     <= 4'd0;
            o_resp_io_mode <= SQI_IO_MODE_IN;
         end else begin
            case (state_reg)
               ST_IDLE: begin
                  state_reg <= ST_INSTR;
                  cnt_reg   <= 3'd0;
               end
               ST_INSTR: begin
                  if (sck_rise) begin
                     if (cnt_reg == 3'd0) begin
                        nib_reg <= i_resp_sio;
                        cnt_reg <= 3'd1;
                     end else begin
                        cnt_reg <= 3'd0;
                        case ({nib_reg, i_resp_sio})
                           8'h03: begin
                              is_read_reg <= 1'b1;
                              state_reg   <= ST_ADDR;
                           end
                           8'h02: begin
                              is_read_reg <= 1'b0;
                              state_reg   <= ST_ADDR;
                           end
                           default: state_reg <= ST_IGNORE;
                        endcase
                     end
                  end
               end
               ST_ADDR: begin
                  if (sck_rise) begin
                     o_resp_mem_addr <= {o_resp_mem_addr[11:0], i_resp_sio};
                     if (cnt_reg == 3'd3) begin
                        cnt_reg       <= 3'd0;
                        state_reg     <= is_read_reg ? ST_DUMMY : ST_WDATA;
                        o_resp_mem_rd <= is_read_reg;
                     end else begin
                        cnt_reg <= cnt_reg + 3'd1;
                     end
                  end
               end
               ST_DUMMY: begin
                  if (sck_rise) begin
                     if (cnt_reg == 3'd1) begin
                        cnt_reg   <= 3'd0;
                        state_reg <= ST_RDATA;
                     end else begin
                        cnt_reg <= cnt_reg + 3'd1;
                     end
                  end
               end
               ST_RDATA: begin
                  if (sck_fall) begin
                     o_resp_io_mode <= SQI_IO_MODE_OUT;
                     if (cnt_reg == 3'd0) begin
                        // low nibble is parked so the prefetch may overwrite rbyte_reg
                        o_resp_sio      <= rbyte_reg[7:4];
                        nib_reg         <= rbyte_reg[3:0];
                        o_resp_mem_addr <= o_resp_mem_addr + 16'd1;
                        o_resp_mem_rd   <= 1'b1;
                        cnt_reg         <= 3'd1;
                     end else begin
                        o_resp_sio <= nib_reg;
                        cnt_reg    <= 3'd0;
                     end
                  end
               end
               ST_WDATA: begin
                  if (sck_rise) begin
                     if (cnt_reg == 3'd0) begin
                        nib_reg <= i_resp_sio;
                        cnt_reg <= 3'd1;
                     end else begin
                        o_resp_mem_wdata <= {nib_reg, i_resp_sio};
                        o_resp_mem_wr    <= 1'b1;
                        cnt_reg          <= 3'd0;
                     end
                  end
               end
               ST_IGNORE: begin
                  cnt_reg <= 3'd0;
               end
               default: begin
                  state_reg <= ST_IDLE;
                  cnt_reg   <= 3'd0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_idli_sqi_resp_m.sv
// Randomized SQI initiator with a memory-level reference model; a monitor
// checks strobes and read nibbles against scoreboard queues.
module tb_idli_sqi_resp_m;
   import idli_sqi_pkg::*;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         sck = 1'b0;
   logic         cs = 1'b1;
   logic [3:0]   sio_in = 4'd0;
   logic [3:0]   sio_out;
   sqi_io_mode_t io_mode;
   logic [15:0]  mem_addr;
   logic         mem_rd;
   logic [7:0]   mem_rdata = 8'd0;
   logic         mem_wr;
   logic [7:0]   mem_wdata;

   always #5 clk = ~clk;

   idli_sqi_resp_m dut (
      .i_resp_gck       (clk),
      .i_resp_rst_n     (rst_n),
      .i_resp_sck       (sck),
      .i_resp_cs        (cs),
      .i_resp_sio       (sio_in),
      .o_resp_sio       (sio_out),
      .o_resp_io_mode   (io_mode),
      .o_resp_mem_addr  (mem_addr),
      .o_resp_mem_rd    (mem_rd),
      .i_resp_mem_rdata (mem_rdata),
      .o_resp_mem_wr    (mem_wr),
      .o_resp_mem_wdata (mem_wdata)
   );

   int total = 0;
   int bad = 0;
   int half = 2;

   logic [7:0]  init_mem [0:65535];
   logic [7:0]  ref_mem  [0:65535];
   logic [7:0]  phys     [0:65535];
   bit          phys_valid [0:65535];

   logic [15:0] exp_rd  [$];
   logic [23:0] exp_wr  [$];
   logic [3:0]  exp_nib [$];
   logic [7:0]  wbytes  [$];

   logic        mon_sck_q;
   logic        mon_rd_q;
   logic        mon_wr_q;
   logic [15:0] r_addr;
   int          r_n;

   // backing memory: read data valid the cycle after the strobe
   always @(posedge clk) begin
      if (mem_rd)
         mem_rdata <= phys_valid[mem_addr] ? phys[mem_addr] : init_mem[mem_addr];
      if (mem_wr) begin
         phys[mem_addr]       <= mem_wdata;
         phys_valid[mem_addr] <= 1'b1;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   task automatic unexpected(input string name, input logic [31:0] act);
      total++;
      bad++;
      $display("FAIL %s: got strobe with %0h, required none", name, act);
   endtask

   initial begin
      mon_sck_q = 1'b0;
      mon_rd_q  = 1'b0;
      mon_wr_q  = 1'b0;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (mem_rd || mem_wr)
               check("rd_wr_excl", 32'(mem_rd & mem_wr), 32'd0);
            if (mem_rd) begin
               check("rd_pulse_len", 32'(mon_rd_q), 32'd0);
               if (exp_rd.size() == 0) unexpected("rd_unexpected", 32'(mem_addr));
               else check("rd_addr", 32'(mem_addr), 32'(exp_rd.pop_front()));
            end
            if (mem_wr) begin
               check("wr_pulse_len", 32'(mon_wr_q), 32'd0);
               if (exp_wr.size() == 0) unexpected("wr_unexpected", 32'({mem_addr, mem_wdata}));
               else check("wr_addr_data", 32'({mem_addr, mem_wdata}), 32'(exp_wr.pop_front()));
            end
            if (sck && !mon_sck_q && !cs) begin
               if (exp_nib.size() > 0) begin
                  check("io_mode_out", 32'(io_mode), 32'(SQI_IO_MODE_OUT));
                  check("rd_nibble", 32'(sio_out), 32'(exp_nib.pop_front()));
               end else begin
                  check("io_mode_in", 32'(io_mode), 32'(SQI_IO_MODE_IN));
                  check("sio_idle", 32'(sio_out), 32'd0);
               end
            end
         end
         mon_sck_q = sck;
         mon_rd_q  = mem_rd;
         mon_wr_q  = mem_wr;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_nib(input logic [3:0] n);
      sio_in = n;
      tick(half);
      sck = 1'b1;
      tick(half);
      sck = 1'b0;
   endtask

   task automatic send_addr(input logic [15:0] a);
      for (int i = 3; i >= 0; i--) send_nib(a[i*4 +: 4]);
   endtask

   task automatic cs_low();
      tick(1);
      cs = 1'b0;
      tick(2);
   endtask

   task automatic cs_high();
      tick(2);
      cs = 1'b1;
      sio_in = 4'd0;
      tick(3);
   endtask

   task automatic do_write(input logic [15:0] addr, input int n);
      logic [15:0] a;
      logic [7:0]  b;
      a = addr;
      half = $urandom_range(2, 4);
      $display("txn write addr=%04h bytes=%0d half=%0d", addr, n, half);
      cs_low();
      send_nib(4'h0);
      send_nib(4'h2);
      send_addr(addr);
      for (int k = 0; k < n; k++) begin
         if (wbytes.size() > 0) b = wbytes.pop_front();
         else b = 8'($urandom);
         exp_wr.push_back({a, b});
         ref_mem[a] = b;
         send_nib(b[7:4]);
         send_nib(b[3:0]);
         a = a + 16'd1;
      end
      cs_high();
   endtask

   // a prefetch follows every high-nibble fall, including the trailing one
   task automatic do_read(input logic [15:0] addr, input int n, input bit keep_cs);
      logic [15:0] a;
      logic [7:0]  b;
      a = addr;
      half = $urandom_range(2, 4);
      $display("txn read addr=%04h bytes=%0d half=%0d", addr, n, half);
      for (int k = 0; k <= n + 1; k++) exp_rd.push_back(addr + 16'(k));
      if (!keep_cs) cs_low();
      send_nib(4'h0);
      send_nib(4'h3);
      send_addr(addr);
      send_nib(4'($urandom));
      send_nib(4'($urandom));
      for (int k = 0; k < n; k++) begin
         b = ref_mem[a];
         exp_nib.push_back(b[7:4]);
         send_nib(4'($urandom));
         exp_nib.push_back(b[3:0]);
         send_nib(4'($urandom));
         a = a + 16'd1;
      end
      cs_high();
   endtask

   task automatic do_ignore();
      half = $urandom_range(2, 4);
      $display("txn unknown instr=9f nibbles=8 half=%0d", half);
      cs_low();
      send_nib(4'h9);
      send_nib(4'hF);
      for (int k = 0; k < 8; k++) send_nib(4'($urandom));
      cs_high();
   endtask

   task automatic do_partial(input logic [15:0] addr);
      half = $urandom_range(2, 4);
      $display("txn partial write addr=%04h half=%0d", addr, half);
      cs_low();
      send_nib(4'h0);
      send_nib(4'h2);
      send_addr(addr);
      send_nib(4'($urandom));
      cs_high();
   endtask

   task automatic do_reset_read(input logic [15:0] addr);
      logic [7:0] b;
      half = $urandom_range(2, 4);
      $display("txn read with reset addr=%04h half=%0d", addr, half);
      exp_rd.push_back(addr);
      exp_rd.push_back(addr + 16'd1);
      cs_low();
      send_nib(4'h0);
      send_nib(4'h3);
      send_addr(addr);
      send_nib(4'($urandom));
      send_nib(4'($urandom));
      b = ref_mem[addr];
      exp_nib.push_back(b[7:4]);
      send_nib(4'($urandom));
      tick(1);
      check("pre_reset_io_mode", 32'(io_mode), 32'(SQI_IO_MODE_OUT));
      rst_n = 1'b0;
      #1;
      check("rst_sio", 32'(sio_out), 32'd0);
      check("rst_io_mode", 32'(io_mode), 32'(SQI_IO_MODE_IN));
      check("rst_mem_rd", 32'(mem_rd), 32'd0);
      check("rst_mem_wr", 32'(mem_wr), 32'd0);
      check("rst_mem_addr", 32'(mem_addr), 32'd0);
      check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
      tick(2);
      rst_n = 1'b1;
      tick(3);
   endtask

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached, required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 65536; i++) begin
         init_mem[16'(i)] = 8'($urandom);
         ref_mem[16'(i)]  = init_mem[16'(i)];
      end
      init_mem[16'h1234] = 8'h5C;
      ref_mem[16'h1234]  = 8'h5C;
      init_mem[16'h1235] = 8'h7E;
      ref_mem[16'h1235]  = 8'h7E;

      tick(3);
      check("reset_sio", 32'(sio_out), 32'd0);
      check("reset_io_mode", 32'(io_mode), 32'(SQI_IO_MODE_IN));
      check("reset_mem_rd", 32'(mem_rd), 32'd0);
      check("reset_mem_wr", 32'(mem_wr), 32'd0);
      check("reset_mem_addr", 32'(mem_addr), 32'd0);
      check("reset_mem_wdata", 32'(mem_wdata), 32'd0);
      rst_n = 1'b1;
      tick(2);

      do_read(16'h1234, 2, 1'b0);
      wbytes.push_back(8'hAB);
      do_write(16'h1234, 1);
      do_write(16'hFFFF, 2);
      do_read(16'hFFFF, 2, 1'b0);
      do_ignore();
      do_partial(16'h4321);
      do_write(16'h4321, 1);
      do_read(16'h4321, 1, 1'b0);

      wbytes.push_back(8'hC3);
      do_write(16'h2000, 1);
      do_reset_read(16'h2000);
      do_read(16'h1234, 2, 1'b1);

      for (int t = 0; t < 24; t++) begin
         if ($urandom_range(0, 3) == 0) r_addr = 16'hFFFE + 16'($urandom_range(0, 1));
         else r_addr = 16'($urandom);
         r_n = $urandom_range(1, 4);
         case ($urandom_range(0, 5))
            0, 1:    do_write(r_addr, r_n);
            2, 3:    do_read(r_addr, r_n, 1'b0);
            4:       do_partial(r_addr);
            default: do_ignore();
         endcase
      end

      tick(10);
      check("exp_rd_left", 32'(exp_rd.size()), 32'd0);
      check("exp_wr_left", 32'(exp_wr.size()), 32'd0);
      check("exp_nib_left", 32'(exp_nib.size()), 32'd0);
      check("final_io_mode", 32'(io_mode), 32'(SQI_IO_MODE_IN));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
